pcihello_keys_pio: RTL and testbench

Parametrised Avalon-MM input PIO for the pcihellocore push-button bank: the next generation of the plain keys input port. It synchronises the asynchronous key pins and captures edges per bit into a sticky register, raising a maskable interrupt toward the PCIe host. Debouncing is optional at compile time. It sits on the pcihellocore Avalon interconnect alongside the other PIO slaves, and host software reaches it through the BAR-mapped register window.

---
 rtl/pcihello_keys_pio_pkg.sv | 15 +
 rtl/pcihello_keys_pio_if.sv | 12 +
 rtl/pcihello_keys_pio_debounce.sv | 28 ++
 rtl/pcihello_keys_pio.sv | 91 +++++++++
 tb/tb_pcihello_keys_pio.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/pcihello_keys_pio_pkg.sv
// Shared constants for the pcihellocore keys PIO: register map and edge capture modes.
package keys_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd2;
    localparam logic [1:0] ADDR_RAW     = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_mode_e;

endpackage

// File: rtl/pcihello_keys_pio_if.sv
// Avalon-MM slave port of the keys PIO, plus its level interrupt toward the PCIe core.
interface pcihello_keys_pio_if;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        chipselect;
    logic [31:0] readdata;
    logic        irq;

    modport master (output address, write, writedata, chipselect, input readdata, irq);
    modport slave  (input address, write, writedata, chipselect, output readdata, irq);
endinterface

// File: rtl/pcihello_keys_pio_debounce.sv
// Single-bit debouncer: the output follows the input only after DEBOUNCE_CYCLES of stable mismatch.
module keys_pio_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [CW-1:0] cnt;

    // The counter only runs while raw disagrees with the held value, so it never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            stable <= 1'b1;
        end else if (raw == stable) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable <= raw;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/pcihello_keys_pio.sv
// Push-button input PIO: synchroniser, optional debounce (KEYS_PIO_DEBOUNCE_EN),
// sticky edge capture with W1C, maskable level irq and a registered read mux.
module pcihello_keys_pio
    import keys_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int EDGE_MODE       = 1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    pcihello_keys_pio_if.slave bus,
    input  logic [WIDTH-1:0] in_port
);
    localparam edge_mode_e MODE = edge_mode_e'(2'(EDGE_MODE));

    logic [WIDTH-1:0] sync1, raw, cond, cond_d;
    logic [WIDTH-1:0] edges, irqmask, edgecap, edgecap_n;
    logic [31:0]      rd_mux;
    logic             wr_en;

    assign wr_en = bus.chipselect & bus.write;

    // Idle-high reset level keeps reset release from looking like a key press.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '1;
            raw   <= '1;
        end else begin
            sync1 <= in_port;
            raw   <= sync1;
        end
    end

`ifdef KEYS_PIO_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        keys_pio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk    (clk),
            .reset  (reset),
            .raw    (raw[i]),
            .stable (cond[i])
        );
    end
`else
    assign cond = raw;
`endif

    always_comb begin
        edges = '0;
        case (MODE)
            EDGE_RISE: edges = cond & ~cond_d;
            EDGE_FALL: edges = ~cond & cond_d;
            default:   edges = cond ^ cond_d;
        endcase
    end

    // Clear first, then OR in new edges so a coincident edge survives the W1C.
    always_comb begin
        edgecap_n = edgecap;
        if (wr_en && bus.address == ADDR_EDGECAP)
            edgecap_n = edgecap & ~bus.writedata[WIDTH-1:0];
        edgecap_n = edgecap_n | edges;
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:    rd_mux = 32'(cond);
            ADDR_IRQMASK: rd_mux = 32'(irqmask);
            ADDR_EDGECAP: rd_mux = 32'(edgecap);
            default:      rd_mux = 32'(raw);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cond_d       <= '1;
            irqmask      <= '0;
            edgecap      <= '0;
            bus.readdata <= '0;
        end else begin
            cond_d       <= cond;
            edgecap      <= edgecap_n;
            bus.readdata <= rd_mux;
            if (wr_en && bus.address == ADDR_IRQMASK)
                irqmask <= bus.writedata[WIDTH-1:0];
        end
    end

    assign bus.irq = |(edgecap & irqmask);
endmodule

// File: tb/tb_pcihello_keys_pio.sv
// Bench for pcihello_keys_pio: one falling-edge and one any-edge instance, reads checked via a scoreboard.
module tb_pcihello_keys_pio;
    import keys_pio_pkg::*;

    localparam int W   = 4;
    localparam int DEB = 8;
`ifdef KEYS_PIO_DEBOUNCE_EN
    localparam int LAT = 3 + DEB;
`else
    localparam int LAT = 3;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_f, in_a;
    logic [31:0]  obs, exp_v;
    logic [31:0]  sb[$];
    int           passed = 0;
    int           total  = 0;

    always #5 clk = ~clk;

    pcihello_keys_pio_if bus_f ();
    pcihello_keys_pio_if bus_a ();

    pcihello_keys_pio #(.WIDTH(W), .EDGE_MODE(1), .DEBOUNCE_CYCLES(DEB)) dut_f (
        .clk(clk), .reset(reset), .bus(bus_f), .in_port(in_f)
    );
    pcihello_keys_pio #(.WIDTH(W), .EDGE_MODE(2), .DEBOUNCE_CYCLES(DEB)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a), .in_port(in_a)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit sel, input logic [1:0] a, input logic [31:0] d);
        if (sel) begin
            bus_a.address = a; bus_a.writedata = d; bus_a.write = 1'b1; bus_a.chipselect = 1'b1;
        end else begin
            bus_f.address = a; bus_f.writedata = d; bus_f.write = 1'b1; bus_f.chipselect = 1'b1;
        end
        tick();
        bus_a.write = 1'b0; bus_a.chipselect = 1'b0;
        bus_f.write = 1'b0; bus_f.chipselect = 1'b0;
    endtask

    // Expected value goes on the scoreboard as the read is issued; the caller pops and compares.
    task automatic issue_rd(input bit sel, input logic [1:0] a, input logic [31:0] e);
        sb.push_back(e);
        if (sel) bus_a.address = a; else bus_f.address = a;
        tick();
        obs = sel ? bus_a.readdata : bus_f.readdata;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_f = 4'hF; in_a = 4'hF;
        bus_f.address = '0; bus_f.write = 0; bus_f.chipselect = 0; bus_f.writedata = '0;
        bus_a.address = '0; bus_a.write = 0; bus_a.chipselect = 0; bus_a.writedata = '0;
        repeat (3) tick();
        total++; if (bus_f.readdata !== 32'h0) $display("FAIL reset_readdata: got %h want 0", bus_f.readdata); else passed++;
        total++; if (bus_f.irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", bus_f.irq); else passed++;
        reset = 1'b0;
        issue_rd(0, ADDR_DATA, 32'hF);
        exp_v = sb.pop_front(); total++; if (obs !== exp_v) $display("FAIL reset_data: got %h want %h", obs, exp_v); else passed++;
        issue_rd(0, ADDR_EDGECAP, 32'h0);
        exp_v = sb.pop_front(); total++; if (obs !== exp_v) $display("FAIL reset_edgecap: got %h want %h", obs, exp_v); else passed++;
        issue_rd(0, ADDR_RAW, 32'hF);
        exp_v = sb.pop_front(); total++; if (obs !== exp_v) $display("FAIL reset_raw: got %h want %h", obs, exp_v); else passed++;
    endtask

    task automatic test_fall_irq();
        wr(0, ADDR_IRQMASK, 32'h1);
        issue_rd(0, ADDR_IRQMASK, 32'h1);
        exp_v = sb.pop_front(); total++; if (obs !== exp_v) $display("FAIL irqmask_rb: got %h want %h", obs, exp_v); else passed++;
        in_f = 4'hE;
        repeat (LAT - 1) tick();
        total++; if (bus_f.irq !== 1'b0) $display("FAIL fall_irq_early: got %b want 0", bus_f.irq); else passed++;
        tick();
        total++; if (bus_f.irq !== 1'b1) $display("FAIL fall_irq_latency: got %b want 1", bus_f.irq); else passed++;
        issue_rd(0, ADDR_EDGECAP, 32'h1);
        exp_v = sb.pop_front(); total++; if (obs !== exp_v) $display("FAIL fall_edgecap: got %h want %h", obs, exp_v); else passed++;
        wr(0, ADDR_EDGECAP, 32'h1);
        total++; if (bus_f.irq !== 1'b0) $display("FAIL w1c_irq: got %b want 0", bus_f.irq); else passed++;
        issue_rd(0, ADDR_EDGECAP, 32'h0);
        exp_v = sb.pop_front(); total++; if (obs !== exp_v) $display("FAIL w1c_edgecap: got %h want %h", obs, exp_v); else passed++;
        in_f = 4'hF;
        repeat (LAT + 2) tick();
        issue_rd(0, ADDR_EDGECAP, 32'h0);
        exp_v = sb.pop_front(); total++; if (obs !== exp_v) $display("FAIL rise_ignored: got %h want %h", obs, exp_v); else passed++;
    endtask

    task automatic test_mask();
        wr(0, ADDR_IRQMASK, 32'h0);
        in_f = 4'hB;
        repeat (LAT + 1) tick();
        issue_rd(0, ADDR_EDGECAP, 32'h4);
        exp_v = sb.pop_front(); total++; if (obs !== exp_v) $display("FAIL mask_edgecap: got %h want %h", obs, exp_v); else passed++;
        total++; if (bus_f.irq !== 1'b0) $display("FAIL masked_irq: got %b want 0", bus_f.irq); else passed++;
        issue_rd(0, ADDR_DATA, 32'hB);
        exp_v = sb.pop_front(); total++; if (obs !== exp_v) $display("FAIL mask_data: got %h want %h", obs, exp_v); else passed++;
        wr(0, ADDR_IRQMASK, 32'h4);
        total++; if (bus_f.irq !== 1'b1) $display("FAIL unmask_irq: got %b want 1", bus_f.irq); else passed++;
        wr(0, ADDR_EDGECAP, 32'h4);
        in_f = 4'hF;
        repeat (LAT + 2) tick();
        issue_rd(0, ADDR_EDGECAP, 32'h0);
        exp_v = sb.pop_front(); total++; if (obs !== exp_v) $display("FAIL mask_clear: got %h want %h", obs, exp_v); else passed++;
    endtask

    task automatic test_w1c_collision();
        in_f = 4'hE;
        repeat (LAT + 1) tick();
        in_f = 4'hF;
        repeat (LAT + 2) tick();
        in_f = 4'hE;
        repeat (LAT - 1) tick();
        wr(0, ADDR_EDGECAP, 32'h1);
        issue_rd(0, ADDR_EDGECAP, 32'h1);
        exp_v = sb.pop_front(); total++; if (obs !== exp_v) $display("FAIL set_wins: got %h want %h", obs, exp_v); else passed++;
        wr(0, ADDR_EDGECAP, 32'hF);
        in_f = 4'hF;
        repeat (LAT + 2) tick();
        issue_rd(0, ADDR_EDGECAP, 32'h0);
        exp_v = sb.pop_front(); total++; if (obs !== exp_v) $display("FAIL collision_clear: got %h want %h", obs, exp_v); else passed++;
    endtask

`ifdef KEYS_PIO_DEBOUNCE_EN
    task automatic test_debounce();
        in_f = 4'hD;
        repeat (2) tick();
        issue_rd(0, ADDR_RAW, 32'hD);
        exp_v = sb.pop_front(); total++; if (obs !== exp_v) $display("FAIL glitch_raw: got %h want %h", obs, exp_v); else passed++;
        issue_rd(0, ADDR_DATA, 32'hF);
        exp_v = sb.pop_front(); total++; if (obs !== exp_v) $display("FAIL glitch_data: got %h want %h", obs, exp_v); else passed++;
        tick();
        in_f = 4'hF;
        repeat (20) tick();
        issue_rd(0, ADDR_EDGECAP, 32'h0);
        exp_v = sb.pop_front(); total++; if (obs !== exp_v) $display("FAIL glitch_edge: got %h want %h", obs, exp_v); else passed++;
        in_f = 4'hD;
        repeat (9) tick();
        issue_rd(0, ADDR_DATA, 32'hF);
        exp_v = sb.pop_front(); total++; if (obs !== exp_v) $display("FAIL db_early: got %h want %h", obs, exp_v); else passed++;
        issue_rd(0, ADDR_DATA, 32'hD);
        exp_v = sb.pop_front(); total++; if (obs !== exp_v) $display("FAIL db_data: got %h want %h", obs, exp_v); else passed++;
        issue_rd(0, ADDR_EDGECAP, 32'h2);
        exp_v = sb.pop_front(); total++; if (obs !== exp_v) $display("FAIL db_edgecap: got %h want %h", obs, exp_v); else passed++;
        repeat (10) tick();
        in_f = 4'hF;
        repeat (LAT + 2) tick();
        wr(0, ADDR_EDGECAP, 32'hF);
    endtask
`endif

    task automatic test_any_edge();
        wr(1, ADDR_IRQMASK, 32'h8);
        in_a = 4'h7;
        repeat (LAT + 1) tick();
        issue_rd(1, ADDR_EDGECAP, 32'h8);
        exp_v = sb.pop_front(); total++; if (obs !== exp_v) $display("FAIL any_press: got %h want %h", obs, exp_v); else passed++;
        total++; if (bus_a.irq !== 1'b1) $display("FAIL any_irq: got %b want 1", bus_a.irq); else passed++;
        wr(1, ADDR_EDGECAP, 32'h8);
        issue_rd(1, ADDR_EDGECAP, 32'h0);
        exp_v = sb.pop_front(); total++; if (obs !== exp_v) $display("FAIL any_clear: got %h want %h", obs, exp_v); else passed++;
        in_a = 4'hF;
        repeat (LAT + 1) tick();
        issue_rd(1, ADDR_EDGECAP, 32'h8);
        exp_v = sb.pop_front(); total++; if (obs !== exp_v) $display("FAIL any_release: got %h want %h", obs, exp_v); else passed++;
    endtask

    task automatic test_reset_mid();
        in_a = 4'h7;
        repeat (6) tick();
        reset = 1'b1;
        in_a = 4'hF;
        repeat (2) tick();
        total++; if (bus_a.irq !== 1'b0) $display("FAIL midrst_irq: got %b want 0", bus_a.irq); else passed++;
        total++; if (bus_a.readdata !== 32'h0) $display("FAIL midrst_readdata: got %h want 0", bus_a.readdata); else passed++;
        reset = 1'b0;
        issue_rd(1, ADDR_DATA, 32'hF);
        exp_v = sb.pop_front(); total++; if (obs !== exp_v) $display("FAIL midrst_data: got %h want %h", obs, exp_v); else passed++;
        repeat (LAT + 2) tick();
        issue_rd(1, ADDR_EDGECAP, 32'h0);
        exp_v = sb.pop_front(); total++; if (obs !== exp_v) $display("FAIL midrst_edgecap: got %h want %h", obs, exp_v); else passed++;
        issue_rd(1, ADDR_IRQMASK, 32'h0);
        exp_v = sb.pop_front(); total++; if (obs !== exp_v) $display("FAIL midrst_irqmask: got %h want %h", obs, exp_v); else passed++;
    endtask

    initial begin
        test_reset();
        test_fall_irq();
        test_mask();
        test_w1c_collision();
`ifdef KEYS_PIO_DEBOUNCE_EN
        test_debounce();
`endif
        test_any_edge();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench still running at %0t", $time);
        $fatal(1);
    end
endmodule
